// File: rtl/fpga_cfg_loader.sv
// Configuration loader: takes a byte stream over valid/ready and serialises it
// into the CLB scan chain, then the connection scan chain, driving scan_clk.
module fpga_cfg_loader #(
    parameter int unsigned CLB_BITS  = 1152,
    parameter int unsigned CONN_BITS = 4608
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cfg_start,
    input  logic       cfg_abort,
    input  logic [7:0] cfg_data,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    output logic       scan_clk,
    output logic       clb_scan_in,
    output logic       clb_scan_en,
    output logic       conn_scan_in,
    output logic       conn_scan_en,
    output logic       core_reset,
    output logic       cfg_busy,
    output logic       cfg_done
);

    localparam int unsigned SEG_MAX   = (CLB_BITS > CONN_BITS) ? CLB_BITS : CONN_BITS;
    localparam int unsigned SEG_W_RAW = $clog2(SEG_MAX + 1);
    // Segment counter must hold at least 8 so the min(8, remaining) compare is exact.
    localparam int unsigned SEG_W     = (SEG_W_RAW < 4) ? 4 : SEG_W_RAW;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned BYTE_W    = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLB_WAIT,
        S_CLB_SHIFT,
        S_CONN_WAIT,
        S_CONN_SHIFT,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_phase;
    logic                w_phase_nxt;
    logic [BYTE_W-1:0]   r_shreg;
    logic [BYTE_W-1:0]   w_shreg_nxt;
    logic [CNT_W-1:0]    r_bitcnt;
    logic [CNT_W-1:0]    w_bitcnt_nxt;
    logic [SEG_W-1:0]    r_seg;
    logic [SEG_W-1:0]    w_seg_nxt;
    logic                w_busy;

    logic r_cfg_ready, r_scan_clk, r_clb_scan_in, r_clb_scan_en;
    logic r_conn_scan_in, r_conn_scan_en, r_core_reset, r_cfg_busy, r_cfg_done;
    logic w_cfg_ready, w_scan_clk, w_clb_scan_in, w_clb_scan_en;
    logic w_conn_scan_in, w_conn_scan_en, w_core_reset, w_cfg_busy, w_cfg_done;

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_phase        <= 1'b0;
            r_shreg        <= '0;
            r_bitcnt       <= '0;
            r_seg          <= '0;
            r_cfg_ready    <= 1'b0;
            r_scan_clk     <= 1'b0;
            r_clb_scan_in  <= 1'b0;
            r_clb_scan_en  <= 1'b0;
            r_conn_scan_in <= 1'b0;
            r_conn_scan_en <= 1'b0;
            r_core_reset   <= 1'b1;
            r_cfg_busy     <= 1'b0;
            r_cfg_done     <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_phase        <= w_phase_nxt;
            r_shreg        <= w_shreg_nxt;
            r_bitcnt       <= w_bitcnt_nxt;
            r_seg          <= w_seg_nxt;
            r_cfg_ready    <= w_cfg_ready;
            r_scan_clk     <= w_scan_clk;
            r_clb_scan_in  <= w_clb_scan_in;
            r_clb_scan_en  <= w_clb_scan_en;
            r_conn_scan_in <= w_conn_scan_in;
            r_conn_scan_en <= w_conn_scan_en;
            r_core_reset   <= w_core_reset;
            r_cfg_busy     <= w_cfg_busy;
            r_cfg_done     <= w_cfg_done;
        end
    end

    // Next state; outputs are a registered function of the next state
    always_comb begin
        w_state_nxt  = r_state;
        w_phase_nxt  = r_phase;
        w_shreg_nxt  = r_shreg;
        w_bitcnt_nxt = r_bitcnt;
        w_seg_nxt    = r_seg;
        w_busy       = (r_state != S_IDLE) && (r_state != S_DONE);

        if (cfg_abort && w_busy) begin
            w_state_nxt = S_IDLE;
            w_phase_nxt = 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (cfg_start) begin
                        w_state_nxt = S_CLB_WAIT;
                        w_seg_nxt   = SEG_W'(CLB_BITS);
                    end
                end
                S_CLB_WAIT, S_CONN_WAIT: begin
                    if (cfg_valid) begin
                        w_shreg_nxt  = cfg_data;
                        w_bitcnt_nxt = (r_seg >= SEG_W'(8)) ? CNT_W'(8) : r_seg[CNT_W-1:0];
                        w_phase_nxt  = 1'b0;
                        w_state_nxt  = (r_state == S_CLB_WAIT) ? S_CLB_SHIFT : S_CONN_SHIFT;
                    end
                end
                S_CLB_SHIFT, S_CONN_SHIFT: begin
                    if (!r_phase) begin
                        w_phase_nxt = 1'b1;
                    end else begin
                        w_phase_nxt  = 1'b0;
                        w_shreg_nxt  = {1'b0, r_shreg[BYTE_W-1:1]};
                        w_bitcnt_nxt = r_bitcnt - CNT_W'(1);
                        w_seg_nxt    = r_seg - SEG_W'(1);
                        if (r_bitcnt == CNT_W'(1)) begin
                            if (r_seg != SEG_W'(1)) begin
                                w_state_nxt = (r_state == S_CLB_SHIFT) ? S_CLB_WAIT : S_CONN_WAIT;
                            end else if (r_state == S_CLB_SHIFT) begin
                                w_state_nxt = S_CONN_WAIT;
                                w_seg_nxt   = SEG_W'(CONN_BITS);
                            end else begin
                                w_state_nxt = S_DONE;
                            end
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end

        w_cfg_ready    = (w_state_nxt == S_CLB_WAIT) || (w_state_nxt == S_CONN_WAIT);
        w_scan_clk     = ((w_state_nxt == S_CLB_SHIFT) || (w_state_nxt == S_CONN_SHIFT)) && w_phase_nxt;
        w_clb_scan_en  = (w_state_nxt == S_CLB_WAIT) || (w_state_nxt == S_CLB_SHIFT);
        w_conn_scan_en = (w_state_nxt == S_CONN_WAIT) || (w_state_nxt == S_CONN_SHIFT);
        w_clb_scan_in  = (w_state_nxt == S_CLB_SHIFT) && w_shreg_nxt[0];
        w_conn_scan_in = (w_state_nxt == S_CONN_SHIFT) && w_shreg_nxt[0];
        w_core_reset   = (w_state_nxt != S_DONE);
        w_cfg_busy     = (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
        w_cfg_done     = (w_state_nxt == S_DONE);
    end

    assign cfg_ready    = r_cfg_ready;
    assign scan_clk     = r_scan_clk;
    assign clb_scan_in  = r_clb_scan_in;
    assign clb_scan_en  = r_clb_scan_en;
    assign conn_scan_in = r_conn_scan_in;
    assign conn_scan_en = r_conn_scan_en;
    assign core_reset   = r_core_reset;
    assign cfg_busy     = r_cfg_busy;
    assign cfg_done     = r_cfg_done;

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Bench for fpga_cfg_loader: cycle-level behavioural model plus scan-chain
// capture scoreboard, driven by directed and randomized image loads.
module tb_fpga_cfg_loader;

    localparam int unsigned CLB_BITS   = 12;
    localparam int unsigned CONN_BITS  = 5;
    localparam int unsigned CLB_BYTES  = (CLB_BITS + 7) / 8;
    localparam int unsigned CONN_BYTES = (CONN_BITS + 7) / 8;
    localparam int unsigned N_BYTES    = CLB_BYTES + CONN_BYTES;
    localparam logic [8:0]  RST_VEC    = 9'b000000100;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cfg_start = 1'b0;
    logic       cfg_abort = 1'b0;
    logic [7:0] cfg_data = 8'h00;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready, scan_clk, clb_scan_in, clb_scan_en;
    logic       conn_scan_in, conn_scan_en, core_reset, cfg_busy, cfg_done;
    logic [8:0] dut_vec;

    int n_tests = 0;
    int n_fail  = 0;

    logic       clb_q[$];
    logic       conn_q[$];
    logic [7:0] img[N_BYTES];

    fpga_cfg_loader #(.CLB_BITS(CLB_BITS), .CONN_BITS(CONN_BITS)) dut (
        .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .scan_clk(scan_clk), .clb_scan_in(clb_scan_in), .clb_scan_en(clb_scan_en),
        .conn_scan_in(conn_scan_in), .conn_scan_en(conn_scan_en),
        .core_reset(core_reset), .cfg_busy(cfg_busy), .cfg_done(cfg_done)
    );

    always #5 clk = ~clk;

    assign dut_vec = {cfg_ready, scan_clk, clb_scan_in, clb_scan_en, conn_scan_in,
                      conn_scan_en, core_reset, cfg_busy, cfg_done};

    // What the core would capture on each scan_clk rise
    always @(posedge scan_clk) begin
        if (clb_scan_en)  clb_q.push_back(clb_scan_in);
        if (conn_scan_en) conn_q.push_back(conn_scan_in);
    end

    // Behavioural model: mode 0 idle, 1 CLB, 2 CONN, 3 done; a byte occupies 2k cycles
    int         m_mode = 0;
    int         m_left = 0;
    int         m_sh   = 0;
    int         m_pos  = 0;
    int         m_k    = 0;
    logic [7:0] m_byte = 8'h00;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_mode = 0; m_sh = 0; m_pos = 0; m_left = 0;
        end else if ((m_mode == 1 || m_mode == 2) && cfg_abort) begin
            m_mode = 0; m_sh = 0; m_pos = 0;
        end else if (m_mode == 0 || m_mode == 3) begin
            if (cfg_start) begin
                m_mode = 1; m_left = CLB_BITS; m_sh = 0;
            end
        end else if (m_sh == 0) begin
            if (cfg_valid) begin
                m_byte = cfg_data;
                m_k    = (m_left < 8) ? m_left : 8;
                m_sh   = 2 * m_k;
                m_pos  = 0;
            end
        end else begin
            m_sh  = m_sh - 1;
            m_pos = m_pos + 1;
            if (m_sh == 0) begin
                m_left = m_left - m_k;
                if (m_left == 0) begin
                    if (m_mode == 1) begin
                        m_mode = 2; m_left = CONN_BITS;
                    end else begin
                        m_mode = 3;
                    end
                end
            end
        end
    end

    function automatic logic [8:0] model_vec();
        logic busy, shifting, ph, b;
        busy     = (m_mode == 1) || (m_mode == 2);
        shifting = busy && (m_sh > 0);
        ph       = (m_pos % 2) == 1;
        b        = m_byte[(m_pos / 2) % 8];
        return {busy && (m_sh == 0), shifting && ph, (m_mode == 1) && shifting && b,
                m_mode == 1, (m_mode == 2) && shifting && b, m_mode == 2,
                m_mode != 3, busy, m_mode == 3};
    endfunction

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (reset) begin
            n_tests++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL cycle_outputs t=%0t got=%b expected=%b", $time, dut_vec, model_vec());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_seq(input string name, input bit is_conn, input logic [31:0] exp, input int n);
        logic [31:0] act;
        int sz;
        act = '0;
        sz  = is_conn ? conn_q.size() : clb_q.size();
        for (int i = 0; i < sz && i < 32; i++) act[i] = is_conn ? conn_q[i] : clb_q[i];
        check({name, "_len"}, 32'(sz), 32'(n));
        check({name, "_bits"}, act, exp);
    endtask

    // Expected chain contents straight from the image bytes, LSB first, padding dropped
    function automatic logic [31:0] img_bits(input bit is_conn);
        logic [31:0] v;
        logic [7:0]  bv;
        int n, base;
        v    = '0;
        n    = is_conn ? CONN_BITS : CLB_BITS;
        base = is_conn ? CLB_BYTES : 0;
        for (int i = 0; i < n; i++) begin
            bv   = img[base + i / 8];
            v[i] = bv[i % 8];
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        clb_q.delete();
        conn_q.delete();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        check("start_ready", 32'(cfg_ready), 32'd1);
        check("start_busy", 32'(cfg_busy), 32'd1);
        check("start_core_reset", 32'(core_reset), 32'd1);
        check("start_done", 32'(cfg_done), 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit got;
        repeat (gap) begin
            cfg_valid = 1'b0;
            cfg_data  = 8'($urandom);
            tick();
        end
        cfg_valid = 1'b1;
        cfg_data  = b;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            got = cfg_ready;
            tick();
        end
        if (!got) check("handshake_timeout", 32'd0, 32'd1);
        cfg_valid = 1'b0;
    endtask

    task automatic load(input int gap, input bit poke);
        int g;
        start_load();
        for (int b = 0; b < N_BYTES; b++) begin
            g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
            send_byte(img[b], g);
            if (poke && b == 0) begin
                repeat (4) tick();
                cfg_start = 1'b1;
                tick();
                cfg_start = 1'b0;
            end
        end
        for (int i = 0; i < 200 && !cfg_done; i++) tick();
        check("done_reached", 32'(cfg_done), 32'd1);
        check("done_core_reset", 32'(core_reset), 32'd0);
        check("done_scan_clk", 32'(scan_clk), 32'd0);
        check("done_conn_en", 32'(conn_scan_en), 32'd0);
        check_seq("model_clb", 1'b0, img_bits(1'b0), CLB_BITS);
        check_seq("model_conn", 1'b1, img_bits(1'b1), CONN_BITS);
    endtask

    task automatic set_nominal();
        img[0] = 8'hA5; img[1] = 8'h03; img[2] = 8'h1B;
    endtask

    initial begin
        bit found;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'(dut_vec), 32'(RST_VEC));
        reset = 1'b1;
        tick();

        set_nominal();
        load(0, 1'b0);
        check_seq("nominal_clb", 1'b0, 32'h3A5, 12);
        check_seq("nominal_conn", 1'b1, 32'h1B, 5);

        load(5, 1'b0);
        check_seq("backpressure_clb", 1'b0, 32'h3A5, 12);
        check_seq("backpressure_conn", 1'b1, 32'h1B, 5);

        img[0] = 8'hFF; img[1] = 8'hFF; img[2] = 8'hFF;
        load(0, 1'b0);
        check_seq("reload_clb", 1'b0, 32'hFFF, 12);
        check_seq("reload_conn", 1'b1, 32'h1F, 5);

        // Abort during the third CLB bit
        set_nominal();
        start_load();
        send_byte(img[0], 0);
        for (int i = 0; i < 100 && clb_q.size() < 2; i++) tick();
        tick();
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        check("abort_busy", 32'(cfg_busy), 32'd0);
        check("abort_clb_en", 32'(clb_scan_en), 32'd0);
        check("abort_conn_en", 32'(conn_scan_en), 32'd0);
        check("abort_core_reset", 32'(core_reset), 32'd1);
        check("abort_done", 32'(cfg_done), 32'd0);
        check("abort_scan_clk", 32'(scan_clk), 32'd0);
        check("abort_bits_captured", 32'(clb_q.size()), 32'd2);
        repeat (3) tick();
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        check("abort_idle_ignored", 32'(cfg_busy), 32'd0);
        load(0, 1'b0);
        check_seq("after_abort_clb", 1'b0, 32'h3A5, 12);
        check_seq("after_abort_conn", 1'b1, 32'h1B, 5);

        load(0, 1'b1);
        check_seq("start_busy_clb", 1'b0, 32'h3A5, 12);
        check_seq("start_busy_conn", 1'b1, 32'h1B, 5);

        for (int it = 0; it < 8; it++) begin
            for (int b = 0; b < N_BYTES; b++) img[b] = 8'($urandom);
            load(-1, 1'b0);
        end

        // Asynchronous reset in the middle of a CONN phase B
        set_nominal();
        start_load();
        for (int b = 0; b < N_BYTES; b++) send_byte(img[b], 0);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            found = conn_scan_en && scan_clk;
        end
        check("async_conn_phase_b_seen", 32'(found), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_outputs", 32'(dut_vec), 32'(RST_VEC));
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        load(0, 1'b0);
        check_seq("after_reset_clb", 1'b0, 32'h3A5, 12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fpga_cfg_loader.md
# fpga_cfg_loader

Configuration loader for `fpga_core`. It accepts a byte stream over a valid/ready handshake and serialises it into the core's two scan chains, CLB first and connection second. It generates the shared `scan_clk` and the per-chain enables, and holds the fabric in reset until both chains are fully loaded. It sits between the host-side configuration port and `fpga_core`.

## Interface
Parameters:
- `CLB_BITS`, 1152: length of the CLB scan chain in bits (≥1).
- `CONN_BITS`, 4608: length of the connection scan chain in bits (≥1).

Ports:
- `clk`  input  1  system clock; all state is updated on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `cfg_start`  input  1  1-cycle pulse that begins a load; honoured only in IDLE or DONE.
- `cfg_abort`  input  1  aborts a load in progress and returns to IDLE.
- `cfg_data`  input  8  configuration byte, LSB shifted first.
- `cfg_valid`  input  1  `cfg_data` is valid.
- `cfg_ready`  output  1  loader accepts a byte this cycle.
- `scan_clk`  output  1  registered scan clock to the core.
- `clb_scan_in`, `clb_scan_en`  output  1 each  CLB chain data and enable.
- `conn_scan_in`, `conn_scan_en`  output  1 each  connection chain data and enable.
- `core_reset`  output  1  active-high reset to `fpga_core`.
- `cfg_busy`  output  1  high in any state other than IDLE and DONE.
- `cfg_done`  output  1  high in DONE.

## Operation
- States: IDLE, CLB_WAIT, CLB_SHIFT, CONN_WAIT, CONN_SHIFT, DONE.
- **IDLE** → CLB_WAIT on `cfg_start`. This transition also loads the segment counter with `CLB_BITS`.
- **DONE** → CLB_WAIT on `cfg_start`. This restarts the load: it clears `cfg_done` and reasserts `core_reset`.
- **WAIT states:** `cfg_ready`=1. A transfer occurs on a cycle where `cfg_valid` and `cfg_ready` are both 1. On transfer the byte is latched, the per-byte bit count is set to min(8, segment remaining), and the FSM moves to SHIFT.
- **SHIFT, per bit:** two phases.
  - Phase A: `scan_clk`=0, data bit driven on the `*_scan_in` of the active chain.
  - Phase B: `scan_clk`=1; the core captures the bit on this rise.
  - After phase B, the byte and segment counters decrement.
- **End of byte:**
  - If segment bits remain, go to the same segment's WAIT.
  - Else, from CLB_SHIFT go to CONN_WAIT and load the counter with `CONN_BITS`.
  - Else, from CONN_SHIFT go to DONE.
- **Padding:** each segment takes ceil(BITS/8) bytes. Unused high bits of a segment's last byte are discarded and never shifted.
- **Enables:** `clb_scan_en`=1 throughout CLB_WAIT and CLB_SHIFT; `conn_scan_en`=1 throughout CONN_WAIT and CONN_SHIFT; both are 0 otherwise. At most one enable is high at any time.
- **Inactive chain:** its `*_scan_in` is held at 0.
- **Idle scan clock:** `scan_clk`=0 in every non-SHIFT state.
- **Reset to core:** `core_reset`=1 in every state except DONE.
- **`cfg_abort`:** has priority over all other inputs. From any busy state the FSM goes to IDLE next cycle with `scan_clk`=0 and both enables 0. A partially shifted bit is dropped. `cfg_abort` in IDLE or DONE is ignored.
- **`cfg_start` while busy:** ignored.

## Timing
- **Reset values:** state IDLE. Outputs: `core_reset`=1; `cfg_ready`=0; `scan_clk`=0; `clb_scan_in`, `clb_scan_en`, `conn_scan_in` and `conn_scan_en` all 0; `cfg_busy`=0; `cfg_done`=0. All outputs are registered.
- **Start:** `cfg_start` sampled at edge T gives `cfg_ready`=1 and `cfg_busy`=1 from T+1.
- **Byte to first bit:** a byte accepted at edge T puts phase A on the outputs from T+1; `scan_clk` rises at T+2.
- **Throughput:** one bit per 2 clk cycles, so an 8-bit byte takes 16 cycles. `cfg_ready` is 0 throughout SHIFT.
- **Return to WAIT:** `cfg_ready` returns to 1 in the cycle after the last phase B of the byte. In that cycle `scan_clk`=0.
- **Completion:** the last CONN bit's phase B is at cycle N. At N+1 the outputs are `cfg_done`=1, `core_reset`=0, `conn_scan_en`=0 and `scan_clk`=0.
- **Reset mid-load:** outputs go immediately (asynchronously) to their reset values, including `core_reset`=1.

## Test plan
- **Nominal load:** `CLB_BITS`=12, `CONN_BITS`=5, bytes 0xA5, 0x03, 0x1B with `cfg_valid` held high.
  - CLB captures 1,0,1,0,0,1,0,1,1,1,0,0 on 12 `scan_clk` rises.
  - CONN captures 1,1,0,1,1 on 5 rises.
  - `cfg_done`=1 and `core_reset`=0 one cycle after the final rise.
- **Backpressure:** same stream with 5 idle cycles of `cfg_valid`=0 between bytes.
  - The same bit sequences are captured.
  - `scan_clk` stays 0 while waiting.
  - The active enable stays high across the gaps.
- **Abort:** assert `cfg_abort` during the 3rd CLB bit.
  - Next cycle: IDLE, both enables 0, `core_reset`=1, `cfg_done`=0.
  - A fresh `cfg_start` then reloads correctly.
- **Async reset:** drop `reset` in CONN_SHIFT mid-phase B. All outputs reach reset values without waiting for a clk edge.
- **Start while busy:** `cfg_start` pulsed during CLB_SHIFT is ignored; the bit count and captured data are unchanged.
- **Reload from DONE:** `cfg_start` in DONE gives `core_reset`=1 and `cfg_done`=0 next cycle. A second image of 0xFF, 0xFF, 0xFF loads all 1s.
